// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad scanner.
// Scan FSM state encoding (also exported on the STATE debug port),
// matrix geometry, column-4 row assignments and small decode helpers.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_SCAN     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_DEBOUNCE = 3'd2,
        ST_REPORT   = 3'd3,
        ST_HOLD     = 3'd4,
        ST_RELEASE  = 3'd5
    } state_e;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 5;

    // Column 4 carries the non-digit keys, one per row.
    localparam logic [2:0] COL_SPECIAL = 3'd4;
    localparam logic [1:0] ROW_PLUS    = 2'd0;
    localparam logic [1:0] ROW_MUL     = 2'd1;
    localparam logic [1:0] ROW_EQ      = 2'd2;
    localparam logic [1:0] ROW_CLR     = 2'd3;

    // True when exactly one row is pulled low (rows given active-high here).
    function automatic logic single_row(input logic [NUM_ROWS-1:0] rows_low);
        return (rows_low != '0) && ((rows_low & (rows_low - 1'b1)) == '0);
    endfunction

    // Index of the lowest active row; only meaningful when single_row() holds.
    function automatic logic [1:0] row_index(input logic [NUM_ROWS-1:0] rows_low);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_ROWS - 1; i >= 0; i--) begin
            if (rows_low[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: counts consecutive matching samples while enabled and
// pulses done on the N-th one. A mismatch or a disabled cycle restarts the
// count, so the same instance serves press and release filtering.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int N     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic match,
    output logic done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: advance on a matching sample, restart on anything else.
    always_comb begin
        cnt_d = '0;
        done  = 1'b0;
        if (en && match) begin
            if (cnt_q == CNT_W'(N - 1)) begin
                done = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x5 active-low key matrix, debounces presses and
// releases, and emits single-cycle key events (hex digit, '+', '*', '=', 'C').
// Optional feature macro: KEYPAD_REPEAT_EN enables auto-repeat of held hex
// digits; without it each press yields exactly one EVENT.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int CNT_W        = 8,
    parameter int REPEAT_DLY   = 64,
    parameter int REPEAT_PER   = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NUM_ROWS-1:0] ROW_N,
    output logic [NUM_COLS-1:0] COL_N,
    output logic [3:0]          KEY,
    output logic                OP,
    output logic                OPKEY,
    output logic                EQUAL,
    output logic                CLR,
    output logic                EVENT,
    output logic [2:0]          STATE
);

    // The interval timer saturates at the longest configured interval so an
    // oversized hold can never wrap around and alias a shorter one.
    localparam int TIMER_MAX = max3(SETTLE_CYC, REPEAT_DLY, REPEAT_PER);

    logic [NUM_ROWS-1:0] row_meta_q, row_sync_q;
    logic [NUM_ROWS-1:0] rows_low;
    logic [NUM_ROWS-1:0] row_mask;

    state_e              state_q, state_d;
    logic [2:0]          col_q, col_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [1:0]          row_idx_q, row_idx_d;
    logic [CNT_W-1:0]    timer_q, timer_d, timer_inc;

    logic [3:0]          key_q, key_d;
    logic                op_q, op_d;
    logic                opkey_q, opkey_d;
    logic                equal_q, equal_d;
    logic                clr_q, clr_d;
    logic                event_q, event_d;

    logic                db_en, db_match, db_done;

`ifdef KEYPAD_REPEAT_EN
    logic                rep_first_q, rep_first_d;
`endif

    assign rows_low  = ~row_sync_q;
    assign row_mask  = 4'b0001 << row_idx_q;
    assign timer_inc = (timer_q == CNT_W'(TIMER_MAX)) ? timer_q : timer_q + 1'b1;

    // Two-flop synchroniser for the asynchronous row inputs (idle = all high).
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= ROW_N;
            row_sync_q <= row_meta_q;
        end
    end

    // Debouncer qualification: latched row during press, no row during release.
    always_comb begin
        db_en    = 1'b0;
        db_match = 1'b0;
        if (state_q == ST_DEBOUNCE) begin
            db_en    = 1'b1;
            db_match = (rows_low == row_mask);
        end else if (state_q == ST_RELEASE) begin
            db_en    = 1'b1;
            db_match = (rows_low == '0);
        end
    end

    keypad_debounce #(
        .CNT_W (CNT_W),
        .N     (DEBOUNCE_CYC)
    ) u_debounce (
        .clk   (CLK),
        .rst_n (RST_N),
        .en    (db_en),
        .match (db_match),
        .done  (db_done)
    );

    // Scan FSM next state, column selection and interval timing.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        timer_d   = '0;
`ifdef KEYPAD_REPEAT_EN
        rep_first_d = rep_first_q;
`endif
        unique case (state_q)
            ST_SCAN: begin
                if (single_row(rows_low)) begin
                    row_idx_d = row_index(rows_low);
                    state_d   = ST_DEBOUNCE;
                end else begin
                    // Nothing (or an ambiguous multi-row press) on this column.
                    col_d   = (col_q == COL_SPECIAL) ? 3'd0 : col_q + 3'd1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q >= CNT_W'(SETTLE_CYC - 1)) state_d = ST_SCAN;
                else                                    timer_d = timer_inc;
            end
            ST_DEBOUNCE: begin
`ifdef KEYPAD_REPEAT_EN
                rep_first_d = 1'b1;
`endif
                if (!db_match)    state_d = ST_SCAN;
                else if (db_done) state_d = ST_REPORT;
            end
            ST_REPORT: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (rows_low == '0) begin
                    state_d = ST_RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (col_q != COL_SPECIAL) begin
                    if (timer_q == (rep_first_q ? CNT_W'(REPEAT_DLY - 1)
                                                : CNT_W'(REPEAT_PER - 1))) begin
                        state_d     = ST_REPORT;
                        rep_first_d = 1'b0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
`endif
            end
            ST_RELEASE: begin
                if (!db_match) begin
                    state_d = ST_HOLD;
                end else if (db_done) begin
                    col_d   = (col_q == COL_SPECIAL) ? 3'd0 : col_q + 3'd1;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Registered outputs: decode the latched key while entering REPORT.
    always_comb begin
        col_n_d = ~(NUM_COLS'(1) << col_d);
        key_d   = 4'd0;
        op_d    = 1'b0;
        opkey_d = 1'b0;
        equal_d = 1'b0;
        clr_d   = 1'b0;
        event_d = 1'b0;
        if (state_d == ST_REPORT) begin
            event_d = 1'b1;
            if (col_d == COL_SPECIAL) begin
                unique case (row_idx_d)
                    ROW_PLUS: opkey_d = 1'b1;
                    ROW_MUL: begin
                        opkey_d = 1'b1;
                        op_d    = 1'b1;
                    end
                    ROW_EQ:  equal_d = 1'b1;
                    ROW_CLR: clr_d   = 1'b1;
                    default: ;
                endcase
            end else begin
                key_d = {row_idx_d, col_d[1:0]};
            end
        end
    end

    // State, timing and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_SCAN;
            col_q     <= 3'd0;
            col_n_q   <= 5'b11110;
            row_idx_q <= 2'd0;
            timer_q   <= '0;
            key_q     <= 4'd0;
            op_q      <= 1'b0;
            opkey_q   <= 1'b0;
            equal_q   <= 1'b0;
            clr_q     <= 1'b0;
            event_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            col_n_q   <= col_n_d;
            row_idx_q <= row_idx_d;
            timer_q   <= timer_d;
            key_q     <= key_d;
            op_q      <= op_d;
            opkey_q   <= opkey_d;
            equal_q   <= equal_d;
            clr_q     <= clr_d;
            event_q   <= event_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Tracks whether the next repeat uses the initial delay or the period.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rep_first_q <= 1'b1;
        else        rep_first_q <= rep_first_d;
    end
`endif

    assign COL_N = col_n_q;
    assign KEY   = key_q;
    assign OP    = op_q;
    assign OPKEY = opkey_q;
    assign EQUAL = equal_q;
    assign CLR   = clr_q;
    assign EVENT = event_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: table-driven, hand-written and randomized checks of the
// keypad scanner against a key-matrix model and a spec-level event model.
module tb_keypad_encoder;

    localparam int SETTLE = 2;
    localparam int DEB    = 4;
    localparam int RDLY   = 64;
    localparam int RPER   = 16;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [3:0] ROW_N;
    logic [4:0] COL_N;
    logic [3:0] KEY;
    logic       OP, OPKEY, EQUAL, CLR, EVENT;
    logic [2:0] STATE;

    logic [19:0] pressed = '0;   // bit r*5+c = key at row r, column c held

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    keypad_encoder #(
        .SETTLE_CYC   (SETTLE),
        .DEBOUNCE_CYC (DEB),
        .CNT_W        (8),
        .REPEAT_DLY   (RDLY),
        .REPEAT_PER   (RPER)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .ROW_N (ROW_N),
        .COL_N (COL_N),
        .KEY   (KEY),
        .OP    (OP),
        .OPKEY (OPKEY),
        .EQUAL (EQUAL),
        .CLR   (CLR),
        .EVENT (EVENT),
        .STATE (STATE)
    );

    // Key matrix: a held key pulls its row low while its column is driven.
    always_comb begin
        ROW_N = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (pressed[r*5+c] && !COL_N[c]) ROW_N[r] = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [7:0] got_q[$];        // {KEY, OP, OPKEY, EQUAL, CLR} per EVENT
    int   cyc = 0;
    int   low_since = 0;
    int   last_lat = 0;
    int   last_ev_cyc = 0;
    logic prev_ev = 1'b0;
    logic prev_idle = 1'b1;
    int   dbl_cnt = 0;
    int   idle_bad = 0;
    int   col_bad = 0;

    always @(negedge CLK) begin
        cyc++;
        if (ROW_N != 4'hF && prev_idle) low_since = cyc;
        prev_idle = (ROW_N == 4'hF);
        if (RST_N) begin
            if (EVENT) begin
                got_q.push_back({KEY, OP, OPKEY, EQUAL, CLR});
                last_lat    = cyc - low_since;
                last_ev_cyc = cyc;
                if (prev_ev) dbl_cnt++;
            end else if ({KEY, OP, OPKEY, EQUAL, CLR} != 8'h00) begin
                idle_bad++;
            end
            if (!$onehot(~COL_N)) col_bad++;
        end
        prev_ev = EVENT;
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Spec-level model of the event fields for key (r, c).
    function automatic logic [7:0] model_event(input int r, input int c);
        logic [3:0] k;
        logic op, opk, eq, cl;
        k = 4'd0; op = 1'b0; opk = 1'b0; eq = 1'b0; cl = 1'b0;
        if (c < 4) begin
            k = 4'(4 * r + c);
        end else begin
            case (r)
                0: opk = 1'b1;
                1: begin opk = 1'b1; op = 1'b1; end
                2: eq = 1'b1;
                default: cl = 1'b1;
            endcase
        end
        return {k, op, opk, eq, cl};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_event(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (EVENT) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // Press one key, hold it past its event, release, and score the result.
    task automatic press_and_check(input string name, input int r, input int c,
                                   input int hold, input logic [7:0] exp);
        bit seen;
        got_q.delete();
        pressed[r*5+c] = 1'b1;
        wait_event(120, seen);
        check({name, ".seen"}, int'(seen), 1);
        check({name, ".latency_in_window"},
              int'(last_lat >= DEB + 2 && last_lat <= DEB + 4), 1);
        tick(hold);
        pressed[r*5+c] = 1'b0;
        tick(40);
        check({name, ".count"}, got_q.size(), 1);
        if (got_q.size() > 0) check({name, ".fields"}, int'(got_q[0]), int'(exp));
    endtask

    typedef struct {
        string      name;
        int         r;
        int         c;
        int         hold;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    // ---------------- test sequence ----------------
    initial begin
        bit seen;
        int bounce_end;
        int n_exp;

        vecs[0] = '{"hex_A",  2, 2, 20, 8'hA0};
        vecs[1] = '{"mul",    1, 4, 10, 8'h0C};
        vecs[2] = '{"equal",  2, 4, 10, 8'h02};
        vecs[3] = '{"plus",   0, 4, 10, 8'h04};
        vecs[4] = '{"clear",  3, 4, 10, 8'h01};
        vecs[5] = '{"hex_0",  0, 0,  5, 8'h00};
        vecs[6] = '{"hex_F",  3, 3,  5, 8'hF0};

        // Reset state
        tick(3);
        check("rst.state", STATE, 0);
        check("rst.col_n", COL_N, 5'b11110);
        check("rst.event", EVENT, 0);
        check("rst.fields", {KEY, OP, OPKEY, EQUAL, CLR}, 0);
        RST_N = 1'b1;
        tick(2);

        // Table-driven single presses
        for (int i = 0; i < 7; i++) begin
            press_and_check(vecs[i].name, vecs[i].r, vecs[i].c, vecs[i].hold, vecs[i].exp);
        end

        // Bouncing contact on r0,c1: toggles every 2 cycles, then held
        got_q.delete();
        bounce_end = 0;
        for (int i = 0; i < 5; i++) begin
            pressed[1] = ~pressed[1];
            bounce_end = cyc;
            tick(2);
        end
        wait_event(120, seen);
        check("bounce.seen", int'(seen), 1);
        tick(10);
        pressed[1] = 1'b0;
        tick(40);
        check("bounce.count", got_q.size(), 1);
        if (got_q.size() > 0) check("bounce.fields", int'(got_q[0]), 8'h10);
        check("bounce.after_bouncing", int'(last_ev_cyc > bounce_end), 1);

        // Two rows on c0: ambiguous, no event; drop r1 and r0 alone reports
        got_q.delete();
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        tick(60);
        check("multirow.no_event", got_q.size(), 0);
        pressed[5] = 1'b0;
        wait_event(120, seen);
        check("multirow.seen", int'(seen), 1);
        tick(10);
        pressed[0] = 1'b0;
        tick(40);
        check("multirow.count", got_q.size(), 1);
        if (got_q.size() > 0) check("multirow.fields", int'(got_q[0]), 8'h00);

        // Release chatter: brief lifts while held must not re-trigger
        got_q.delete();
        pressed[18] = 1'b1;
        wait_event(120, seen);
        check("chatter.seen", int'(seen), 1);
        for (int i = 0; i < 3; i++) begin
            tick(6);
            pressed[18] = 1'b0;
            tick(2);
            pressed[18] = 1'b1;
        end
        tick(6);
        pressed[18] = 1'b0;
        tick(40);
        check("chatter.count", got_q.size(), 1);

        // Reset asserted two cycles into DEBOUNCE of 'C'
        got_q.delete();
        pressed[19] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge CLK);
            if (STATE == 3'd2) begin
                seen = 1'b1;
                break;
            end
        end
        check("rst_mid.reached_debounce", int'(seen), 1);
        tick(2);
        RST_N = 1'b0;
        #2;
        check("rst_mid.state", STATE, 0);
        check("rst_mid.col_n", COL_N, 5'b11110);
        check("rst_mid.event", EVENT, 0);
        pressed[19] = 1'b0;
        tick(2);
        RST_N = 1'b1;
        tick(40);
        check("rst_mid.no_event", got_q.size(), 0);

        // Long hold of '5' and '+': repeats only for digits when enabled
`ifdef KEYPAD_REPEAT_EN
        n_exp = 3;
`else
        n_exp = 1;
`endif
        got_q.delete();
        pressed[6] = 1'b1;
        wait_event(120, seen);
        tick(RDLY + RPER + RPER / 2);
        pressed[6] = 1'b0;
        tick(40);
        check("long5.count", got_q.size(), n_exp);
        foreach (got_q[i]) check("long5.fields", int'(got_q[i]), 8'h50);
        got_q.delete();
        pressed[4] = 1'b1;
        wait_event(120, seen);
        tick(RDLY + RPER + RPER / 2);
        pressed[4] = 1'b0;
        tick(40);
        check("longplus.count", got_q.size(), 1);

        // Randomized presses against the model
        for (int i = 0; i < 20; i++) begin
            int r, c;
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 4);
            tick($urandom_range(0, 7));
            press_and_check("rand", r, c, $urandom_range(0, 30), model_event(r, c));
        end

        // Whole-run invariants
        check("no_back_to_back_event", dbl_cnt, 0);
        check("idle_fields_zero", idle_bad, 0);
        check("col_n_onehot", col_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
